// File: rtl/seq_divmod_pkg.sv
// -----------------------------------------------------------------------------
// seq_divmod_pkg
// Shared definitions for the sequential restoring divider:
//   - FSM state encodings (binary, 2 bits)
//   - quotient pattern reported on divide-by-zero (all ones, sliced to WIDTH)
// -----------------------------------------------------------------------------
package seq_divmod_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] S_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] S_DONE = 2'd2;

    // Wide enough for any practical WIDTH; users take the low WIDTH bits.
    localparam logic [63:0] DIV_ZERO_QUOT = '1;

endpackage : seq_divmod_pkg

// File: rtl/seq_divmod_div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division step.
// Ports:
//   r      in  WIDTH  current partial remainder (always < b when b != 0)
//   a_msb  in  1      next dividend bit shifted into the remainder
//   b      in  WIDTH  divisor
//   r_next out WIDTH  partial remainder after the step
//   q_bit  out 1      quotient bit produced by the step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r,
    input  logic             a_msb,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    // The shifted remainder can reach 2*b-1, which needs one extra bit.
    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] r_diff;

    assign r_shift = {r, a_msb};
    assign r_diff  = r_shift - {1'b0, b};
    assign q_bit   = (r_shift >= {1'b0, b});
    // When the subtract is kept, the result is < b and fits in WIDTH bits;
    // otherwise r_shift < b, so its top bit is zero as well.
    assign r_next  = q_bit ? r_diff[WIDTH-1:0] : r_shift[WIDTH-1:0];

endmodule : div_step

// File: rtl/seq_divmod.sv
// -----------------------------------------------------------------------------
// seq_divmod
// Multi-cycle unsigned restoring divider: Quot = A / B, Rem = A % B after
// WIDTH iterations. Results are registered and held until the next completion;
// Done is a one-cycle load qualifier for the downstream register stage.
// Ports:
//   Clk      in   1      rising-edge clock
//   Rst      in   1      synchronous active-high reset
//   Start    in   1      request, accepted only when not running
//   A        in   WIDTH  dividend, captured on acceptance
//   B        in   WIDTH  divisor, captured on acceptance
//   Busy     out  1      operation in progress
//   Done     out  1      one-cycle pulse, results valid
//   Quot     out  WIDTH  quotient (all ones on divide-by-zero)
//   Rem      out  WIDTH  remainder (A on divide-by-zero)
//   DivZero  out  1      B was zero for the last completed operation
// -----------------------------------------------------------------------------
module seq_divmod
    import seq_divmod_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quot,
    output logic [WIDTH-1:0] Rem,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;      // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   r_q, r_d;      // partial remainder
    logic [CW-1:0]      cnt_q, cnt_d;  // steps still to perform
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               divz_q, divz_d;

    logic [WIDTH-1:0]   step_r;
    logic               step_q;
    logic [WIDTH-1:0]   a_shift;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r      (r_q),
        .a_msb  (a_q[WIDTH-1]),
        .b      (b_q),
        .r_next (step_r),
        .q_bit  (step_q)
    );

    assign a_shift = {a_q[WIDTH-2:0], step_q};

    always_comb begin
        // NOTE: every variable gets a default here so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        divz_d  = divz_q;

        case (state_q)
            S_RUN: begin
                a_d   = a_shift;
                r_d   = step_r;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quot_d  = a_shift;
                    rem_d   = step_r;
                    divz_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: begin
                // IDLE and DONE behave alike: accept Start, otherwise rest in IDLE.
                state_d = S_IDLE;
                if (Start) begin
                    a_d   = A;
                    b_d   = B;
                    r_d   = '0;
                    cnt_d = CW'(WIDTH);
                    if (B == '0) begin
                        // Complete immediately without iterating.
                        quot_d  = DIV_ZERO_QUOT[WIDTH-1:0];
                        rem_d   = A;
                        divz_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (Rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            divz_q  <= divz_d;
        end
    end

    // Decoded from distinct states, so Busy and Done can never overlap.
    assign Busy    = (state_q == S_RUN);
    assign Done    = (state_q == S_DONE);
    assign Quot    = quot_q;
    assign Rem     = rem_q;
    assign DivZero = divz_q;

endmodule : seq_divmod
